// File: rtl/mont_pkg.sv
// mont_pkg: shared definitions for the bit-serial Montgomery multiplier.
//   mont_state_e        - controller states (IDLE, RUN, REDUCE, DONE)
//   MONT_N_DEFAULT      - default operand/modulus width
//   MONT_TAG_W_DEFAULT  - default request tag width
//   mont_cnt_w()        - width of the iteration counter for a given N
package mont_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REDUCE = 2'd2,
    DONE   = 2'd3
  } mont_state_e;

  localparam int MONT_N_DEFAULT     = 256;
  localparam int MONT_TAG_W_DEFAULT = 4;

  // The counter walks 0..N-1, so $clog2(N) bits suffice (floor of 1 bit).
  function automatic int mont_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mont_step.sv
// mont_step: one Montgomery iteration, purely combinational.
//   t      in  N+2  current accumulator T
//   a      in  N    multiplicand
//   m      in  N    odd modulus
//   b_bit  in  1    current multiplier bit b[i]
//   t_next out N+2  (T + b_bit*a, made even by adding m if odd) / 2
// All sums are carried at N+2 bits; with a, b < m the accumulator stays
// below 2m, so nothing is lost.
module mont_step #(
  parameter int N = 256
) (
  input  logic [N+1:0] t,
  input  logic [N-1:0] a,
  input  logic [N-1:0] m,
  input  logic         b_bit,
  output logic [N+1:0] t_next
);

  logic [N+1:0] t1;
  logic [N+1:0] t2;

  always_comb begin
    t1     = t + (b_bit ? {2'b00, a} : '0);
    // Adding m when t1 is odd makes the sum divisible by 2 without
    // changing its residue mod m.
    t2     = t1 + (t1[0] ? {2'b00, m} : '0);
    t_next = t2 >> 1;
  end

endmodule

// File: rtl/mont_mul_serial.sv
// mont_mul_serial: bit-serial Montgomery multiplier, a*b*2^-N mod m.
// One iteration per clock, valid/ready on both sides, tag pass-through.
//   clk, reset        clock, synchronous active-high reset
//   in_valid/in_ready request handshake (ready only in IDLE)
//   in_a, in_b, in_m  operands (a, b < m) and odd modulus, N bits
//   in_tag            request tag, TAG_W bits
//   out_valid/out_ready result handshake; result held until taken
//   out_result        a*b*2^-N mod m, or 0 when the modulus is even
//   out_tag           tag of the request that produced the result
//   out_err           modulus was even (m = 0 included)
module mont_mul_serial
  import mont_pkg::*;
#(
  parameter int N     = MONT_N_DEFAULT,
  parameter int TAG_W = MONT_TAG_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic [N-1:0]     in_m,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam int              CW     = mont_cnt_w(N);
  localparam logic [CW-1:0]   I_LAST = CW'(N - 1);

  mont_state_e      state_reg, state_next;
  logic [N-1:0]     a_reg, a_next;
  logic [N-1:0]     b_reg, b_next;
  logic [N-1:0]     m_reg, m_next;
  logic [N+1:0]     t_reg, t_next;
  logic [CW-1:0]    i_reg, i_next;
  logic [N-1:0]     result_reg, result_next;
  logic [TAG_W-1:0] tag_reg, tag_next;
  logic             err_reg, err_next;

  logic [N+1:0]     t_step;
  logic [N-1:0]     t_diff;

  mont_step #(.N(N)) u_step (
    .t      (t_reg),
    .a      (a_reg),
    .m      (m_reg),
    .b_bit  (b_reg[i_reg]),
    .t_next (t_step)
  );

  // T < 2m on entry to REDUCE, so T - m fits in N bits whenever T >= m.
  assign t_diff = t_reg[N-1:0] - m_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      m_reg      <= '0;
      t_reg      <= '0;
      i_reg      <= '0;
      result_reg <= '0;
      tag_reg    <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      m_reg      <= m_next;
      t_reg      <= t_next;
      i_reg      <= i_next;
      result_reg <= result_next;
      tag_reg    <= tag_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    m_next      = m_reg;
    t_next      = t_reg;
    i_next      = i_reg;
    result_next = result_reg;
    tag_next    = tag_reg;
    err_next    = err_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          a_next   = in_a;
          b_next   = in_b;
          m_next   = in_m;
          tag_next = in_tag;
          t_next   = '0;
          i_next   = '0;
          if (in_m[0]) begin
            state_next = RUN;
          end else begin
            // Even modulus has no inverse of 2: answer at once with an error.
            result_next = '0;
            err_next    = 1'b1;
            state_next  = DONE;
          end
        end
      end
      RUN: begin
        t_next = t_step;
        i_next = i_reg + 1'b1;
        if (i_reg == I_LAST) begin
          state_next = REDUCE;
        end
      end
      REDUCE: begin
        result_next = (t_reg >= {2'b00, m_reg}) ? t_diff : t_reg[N-1:0];
        err_next    = 1'b0;
        state_next  = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready   = (state_reg == IDLE);
  assign out_valid  = (state_reg == DONE);
  assign out_result = result_reg;
  assign out_tag    = tag_reg;
  assign out_err    = err_reg;

endmodule

// File: tb/tb_mont_mul_serial.sv
// tb_mont_mul_serial: scoreboard bench for mont_mul_serial.
// Two instances: N=8 for directed scenarios (m=13), N=256 for random runs.
// Expected results come from a full-product reference (a*b mod m, then N
// modular halvings) pushed at accept time; a negedge monitor pops and
// compares on every output handshake and checks ready/valid/hold rules.
module tb_mont_mul_serial;

  localparam int NS = 8;
  localparam int NL = 256;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // N = 8 instance
  logic          s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_err;
  logic [NS-1:0] s_in_a, s_in_b, s_in_m, s_out_result;
  logic [TW-1:0] s_in_tag, s_out_tag;
  // N = 256 instance
  logic          l_in_valid, l_in_ready, l_out_valid, l_out_ready, l_out_err;
  logic [NL-1:0] l_in_a, l_in_b, l_in_m, l_out_result;
  logic [TW-1:0] l_in_tag, l_out_tag;

  mont_mul_serial #(.N(NS), .TAG_W(TW)) dut_s (
    .clk(clk), .reset(reset),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_a(s_in_a), .in_b(s_in_b), .in_m(s_in_m), .in_tag(s_in_tag),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_result(s_out_result), .out_tag(s_out_tag), .out_err(s_out_err)
  );

  mont_mul_serial #(.N(NL), .TAG_W(TW)) dut_l (
    .clk(clk), .reset(reset),
    .in_valid(l_in_valid), .in_ready(l_in_ready),
    .in_a(l_in_a), .in_b(l_in_b), .in_m(l_in_m), .in_tag(l_in_tag),
    .out_valid(l_out_valid), .out_ready(l_out_ready),
    .out_result(l_out_result), .out_tag(l_out_tag), .out_err(l_out_err)
  );

  typedef struct {
    logic [255:0] res;
    logic [TW-1:0] tag;
    logic          err;
    int            acc_edge;
    int            lat;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  int total = 0;
  int bad = 0;
  int acc_cnt[2] = '{0, 0};
  int hs_cnt[2] = '{0, 0};
  logic prev_v[2] = '{1'b0, 1'b0};
  logic prev_took[2] = '{1'b0, 1'b0};
  logic [255:0] prev_res[2];
  logic [TW-1:0] prev_tag[2];
  logic prev_err[2];
  logic rand_rdy = 1'b0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timeout waiting for DUT", nm);
  endtask

  // a*b*2^-n mod m from the full product, then n modular halvings.
  function automatic logic [255:0] ref_mont(input logic [255:0] a, input logic [255:0] b,
                                            input logic [255:0] m, input int n);
    logic [511:0] p;
    logic [511:0] r;
    logic [256:0] x;
    p = {256'b0, a} * {256'b0, b};
    r = p % {256'b0, m};
    x = r[256:0];
    for (int k = 0; k < n; k++) begin
      if (x[0]) x = x + {1'b0, m};
      x = x >> 1;
    end
    return x[255:0];
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic send(input int d, input logic [255:0] a, input logic [255:0] b,
                      input logic [255:0] m, input logic [TW-1:0] tag);
    exp_t e;
    int n;
    int w;
    logic rdy;
    w = (d == 0) ? NS : NL;
    if (d == 0) begin
      s_in_valid = 1'b1; s_in_a = a[NS-1:0]; s_in_b = b[NS-1:0];
      s_in_m = m[NS-1:0]; s_in_tag = tag;
    end else begin
      l_in_valid = 1'b1; l_in_a = a; l_in_b = b; l_in_m = m; l_in_tag = tag;
    end
    n = 0;
    forever begin
      @(negedge clk);
      rdy = (d == 0) ? s_in_ready : l_in_ready;
      if (rdy) break;
      n++;
      if (n > 3000) begin
        timeout($sformatf("accept dut%0d tag=%0d", d, tag));
        s_in_valid = 1'b0;
        l_in_valid = 1'b0;
        return;
      end
    end
    e.acc_edge = cyc;
    e.err      = ~m[0];
    e.res      = m[0] ? ref_mont(a, b, m, w) : '0;
    e.tag      = tag;
    e.lat      = m[0] ? (w + 1) : 0;
    @(posedge clk);
    acc_cnt[d]++;
    if (d == 0) sb0.push_back(e); else sb1.push_back(e);
    #1;
    if (d == 0) s_in_valid = 1'b0; else l_in_valid = 1'b0;
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while (acc_cnt[d] != hs_cnt[d]) begin
      @(posedge clk);
      n++;
      if (n > 5000) begin
        timeout($sformatf("drain dut%0d", d));
        break;
      end
    end
    #1;
  endtask

  task automatic wait_valid_s();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_out_valid) break;
      n++;
      if (n > 100) begin
        timeout("out_valid n8");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Reset for one edge; in-flight requests are dropped from the scoreboard.
  task automatic do_reset();
    reset = 1'b1;
    s_in_valid = 1'b0;
    l_in_valid = 1'b0;
    @(posedge clk);
    #1;
    sb0.delete();
    sb1.delete();
    for (int d = 0; d < 2; d++) begin
      hs_cnt[d] = acc_cnt[d];
      prev_v[d] = 1'b0;
      prev_took[d] = 1'b0;
    end
    reset = 1'b0;
  endtask

  task automatic check_dut(input int d, input logic v, input logic r, input logic ir,
                           input logic [255:0] res, input logic [TW-1:0] tag, input logic err);
    exp_t e;
    int qn;
    string p;
    logic idle;
    p = (d == 0) ? "n8" : "n256";
    qn = (d == 0) ? sb0.size() : sb1.size();
    if (qn > 0) e = (d == 0) ? sb0[0] : sb1[0];
    idle = (acc_cnt[d] == hs_cnt[d]);
    chk({p, " in_ready"}, {255'b0, ir}, {255'b0, idle});
    if (idle) chk({p, " out_valid_idle"}, {255'b0, v}, 256'd0);
    if (prev_v[d] && !prev_took[d]) begin
      chk({p, " hold_valid"}, {255'b0, v}, 256'd1);
      chk({p, " hold_result"}, res, prev_res[d]);
      chk({p, " hold_tag"}, {252'b0, tag}, {252'b0, prev_tag[d]});
      chk({p, " hold_err"}, {255'b0, err}, {255'b0, prev_err[d]});
    end
    if (v && !prev_v[d] && qn > 0)
      chk({p, " latency"}, 256'(cyc - e.acc_edge - 1), 256'(e.lat));
    if (v && r) begin
      if (qn == 0) begin
        total++;
        bad++;
        $display("FAIL %s unexpected_output: got tag=%0d result=%0h, required none", p, tag, res);
      end else begin
        chk({p, " result"}, res, e.res);
        chk({p, " tag"}, {252'b0, tag}, {252'b0, e.tag});
        chk({p, " err"}, {255'b0, err}, {255'b0, e.err});
        $display("txn %s tag=%0d result=%0h err=%0d cycle=%0d", p, tag, res, err, cyc);
        if (d == 0) void'(sb0.pop_front()); else void'(sb1.pop_front());
        hs_cnt[d]++;
      end
    end
    prev_v[d] = v;
    prev_took[d] = v && r;
    prev_res[d] = res;
    prev_tag[d] = tag;
    prev_err[d] = err;
  endtask

  // Monitor: samples away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        check_dut(0, s_out_valid, s_out_ready, s_in_ready, {248'b0, s_out_result}, s_out_tag, s_out_err);
        check_dut(1, l_out_valid, l_out_ready, l_in_ready, l_out_result, l_out_tag, l_out_err);
      end
    end
  end

  // Random consumer backpressure for the wide instance.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) l_out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] m;
    logic [255:0] a;
    logic [255:0] b;
    s_in_valid = 1'b0; s_in_a = '0; s_in_b = '0; s_in_m = '0; s_in_tag = '0;
    l_in_valid = 1'b0; l_in_a = '0; l_in_b = '0; l_in_m = '0; l_in_tag = '0;
    s_out_ready = 1'b1;
    l_out_ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("reset in_ready", {255'b0, s_in_ready}, 256'd1);
    chk("reset out_valid", {255'b0, s_out_valid}, 256'd0);
    chk("reset out_result", {248'b0, s_out_result}, 256'd0);
    chk("reset out_tag", {252'b0, s_out_tag}, 256'd0);
    chk("reset out_err", {255'b0, s_out_err}, 256'd0);
    chk("reset wide out_result", l_out_result, 256'd0);

    // Basic, boundary operands and even modulus, issued back to back.
    send(0, 5, 7, 13, 2);
    send(0, 1, 1, 13, 8);
    send(0, 12, 12, 13, 9);
    send(0, 0, 9, 13, 10);
    send(0, 5, 7, 12, 7);
    send(0, 3, 5, 0, 11);
    drain(0);

    // Backpressure: consumer stalls 5 cycles while a new request waits.
    s_out_ready = 1'b0;
    send(0, 5, 7, 13, 3);
    fork
      begin
        wait_valid_s();
        repeat (4) @(posedge clk);
        #1;
        s_out_ready = 1'b1;
      end
      send(0, 3, 4, 13, 4);
    join
    drain(0);

    // Reset in the middle of RUN, then a fresh request.
    send(0, 5, 7, 13, 5);
    repeat (4) @(posedge clk);
    #1;
    do_reset();
    send(0, 5, 7, 13, 6);
    drain(0);

    // Randomised wide operands under random backpressure.
    rand_rdy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      m = rand256();
      if (k % 3 == 0) m[255] = 1'b1;
      m[0] = (k % 8 != 7);
      if (m == 0) m = 256'd2;
      a = rand256() % m;
      b = rand256() % m;
      if (k % 6 == 0) begin
        a = m - 1;
        b = m - 1;
      end
      send(1, a, b, m, k[TW-1:0]);
    end
    drain(1);
    rand_rdy = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
